// File: rtl/alu_issue_unit.sv
// alu_issue_unit: decodes MIPS ALU instructions, drives an external ALU and
// returns a writeback record through a valid/ready handshake.
module alu_issue_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_c,
  input  logic [31:0] alu_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_addr,
  output logic        wb_en,
  output logic        ov_trap,
  output logic        illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t r_state, w_next;
  logic [31:0] r_a, r_b, r_data;
  logic [3:0]  r_c;
  logic [4:0]  r_addr;
  logic        r_ovchk, r_en, r_ov, r_ill;
  logic [31:0] w_a, w_b;
  logic [3:0]  w_c;
  logic [4:0]  w_addr;
  logic        w_legal, w_ovchk, w_same, w_ov;
  logic        w_unused;
  // the rs register number itself is never needed; its value arrives on rs_val
  assign w_unused = ^instr[25:21];
  always_comb begin
    w_legal = 1'b1;
    w_a     = rs_val;
    w_b     = rt_val;
    w_c     = 4'd0;
    w_addr  = instr[15:11];
    w_ovchk = 1'b0;
    if (instr[31:26] == 6'h00) begin
      case (instr[5:0])
        6'h20: w_ovchk = 1'b1;
        6'h21: w_c = 4'd1;
        6'h22: begin w_c = 4'd2; w_ovchk = 1'b1; end
        6'h23: w_c = 4'd3;
        6'h24: w_c = 4'd4;
        6'h25: w_c = 4'd5;
        6'h26: w_c = 4'd6;
        6'h27: w_c = 4'd7;
        6'h2A: w_c = 4'd8;
        6'h2B: w_c = 4'd9;
        6'h00: begin w_c = 4'd10; w_a = {27'b0, instr[10:6]}; end
        6'h02: begin w_c = 4'd11; w_a = {27'b0, instr[10:6]}; end
        6'h03: begin w_c = 4'd12; w_a = {27'b0, instr[10:6]}; end
        6'h04: begin w_c = 4'd10; w_a = {27'b0, rs_val[4:0]}; end
        6'h06: begin w_c = 4'd11; w_a = {27'b0, rs_val[4:0]}; end
        6'h07: begin w_c = 4'd12; w_a = {27'b0, rs_val[4:0]}; end
        default: w_legal = 1'b0;
      endcase
    end else begin
      w_addr = instr[20:16];
      w_b    = {{16{instr[15]}}, instr[15:0]};
      case (instr[31:26])
        6'h08: w_ovchk = 1'b1;
        6'h09: w_c = 4'd1;
        6'h0A: w_c = 4'd8;
        6'h0B: w_c = 4'd9;
        6'h0C: begin w_c = 4'd4; w_b = {16'b0, instr[15:0]}; end
        6'h0D: begin w_c = 4'd5; w_b = {16'b0, instr[15:0]}; end
        6'h0E: begin w_c = 4'd6; w_b = {16'b0, instr[15:0]}; end
        6'h0F: begin w_c = 4'd13; w_a = 32'd0; w_b = {16'b0, instr[15:0]}; end
        default: w_legal = 1'b0;
      endcase
    end
  end
  // signed overflow: operand signs that can overflow, and a result sign flip
  assign w_same = (r_c == 4'd2) ? (r_a[31] ^ r_b[31]) : ~(r_a[31] ^ r_b[31]);
  assign w_ov   = r_ovchk & w_same & (alu_r[31] ^ r_a[31]);
  always_comb begin
    w_next = (r_state == IDLE) ? (in_valid ? (w_legal ? EXEC : DONE) : IDLE) :
             (r_state == EXEC) ? DONE : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_c     <= 4'd0;
      r_addr  <= 5'd0;
      r_ovchk <= 1'b0;
      r_data  <= 32'd0;
      r_en    <= 1'b0;
      r_ov    <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        if (w_legal) begin
          r_a     <= w_a;
          r_b     <= w_b;
          r_c     <= w_c;
          r_addr  <= w_addr;
          r_ovchk <= w_ovchk;
        end else begin
          r_addr <= 5'd0;
          r_data <= 32'd0;
          r_en   <= 1'b0;
          r_ov   <= 1'b0;
          r_ill  <= 1'b1;
        end
      end
      if (r_state == EXEC) begin
        r_data <= alu_r;
        r_ov   <= w_ov;
        r_en   <= (r_addr != 5'd0) & ~w_ov;
        r_ill  <= 1'b0;
      end
    end
  end
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_c     = r_c;
  assign wb_data   = r_data;
  assign wb_addr   = r_addr;
  assign wb_en     = r_en;
  assign ov_trap   = r_ov;
  assign illegal   = r_ill;
endmodule
